cpu_step_ctrl: RTL and testbench
================================

Name: cpu_step_ctrl

Overview:
Execution scheduler for the multi-cycle MIPS core on the DE10-Lite board. The core runs on the 50 MHz board clock gated by a one-cycle clock-enable strobe (cpu_ce), replacing the divided-clock scheme. The block sequences that strobe in three ways: free-run at a switch-selectable rate, single-step from a debounced push button, or stop on a halt request from the core. It also provides a step counter and a heartbeat LED for the hex/LED front panel.

Parameters:
DEBOUNCE_CYCLES, 500000, stable cycles required before a button level is accepted (10 ms at 50 MHz)
RATE_BASE, 50000000, clk cycles per cpu_ce at rate_sel=0; rate_sel=n gives divisor RATE_BASE>>(2n); divisor is floored at 1
CNT_W, 16, step_cnt width

Ports:
clk  input  1  board clock (MAX10_CLK1_50)
reset  input  1  synchronous, active-low reset
run_en  input  1  free-run switch (SW), asynchronous to clk
step_btn  input  1  raw push button, active-low (KEY), asynchronous and bouncing
rate_sel  input  2  free-run rate select
halt_req  input  1  level from core, 1 = stop issuing steps (synchronous to clk)
cpu_ce  output  1  clock-enable strobe to core, one clk cycle wide
state  output  2  00 IDLE, 01 RUN, 10 STEP, 11 HALT
step_cnt  output  CNT_W  number of cpu_ce pulses issued, wrapping
tick_led  output  1  toggles on every cpu_ce

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE; cpu_ce=0; step_cnt=0; tick_led=0; prescaler=0; debounce counter=0; debounced button=1 (released); synchronizers=1 for step_btn and 0 for run_en.
- run_en and step_btn each pass through a 2-FF synchronizer.
- Debounce: a counter clears whenever the synchronized button differs from the debounced level. When the counter reaches DEBOUNCE_CYCLES, the debounced level is updated and the counter clears. A "press" is a debounced 1->0 transition, as a single-cycle pulse. Glitches shorter than DEBOUNCE_CYCLES produce no press.
- All outputs are registered. cpu_ce is asserted for exactly one cycle and never on two consecutive cycles, except when divisor=1 or a burst is active.
- FSM, evaluated each clk; priority is top to bottom within each state:
  - IDLE:
    - run_en_s=1 and halt_req=0 -> RUN, prescaler cleared.
    - Otherwise, press -> STEP.
    - Press with run_en_s=1 and halt_req=1 -> ignored.
  - STEP:
    - cpu_ce=1 for this one cycle, then -> IDLE unconditionally.
  - RUN:
    - halt_req=1 -> HALT, no pulse this cycle even at terminal count.
    - Else run_en_s=0 -> IDLE, prescaler cleared, no pulse.
    - Else prescaler increments. When prescaler >= divisor-1, cpu_ce=1 and prescaler=0.
    - Presses in RUN are ignored.
  - HALT:
    - cpu_ce=0, presses ignored.
    - run_en_s=0 -> IDLE (operator acknowledges by clearing the switch).
- Latency:
  - First RUN pulse: exactly divisor cycles after entering RUN.
  - STEP: cpu_ce is visible the cycle the state register shows STEP, i.e. one cycle after the press pulse.
- Changing rate_sel mid-run takes effect immediately. The >= compare forces a pulse on the next cycle if the prescaler already exceeds the new terminal count.
- step_cnt increments on every cpu_ce and wraps from all-ones to 0. tick_led inverts on every cpu_ce.
- Reset mid-pulse or mid-debounce: the pulse is dropped, no partial press survives, and all state returns to reset values.

Optional Feature:
CPU_STEP_BURST_EN
- When defined: adds input burst_len[7:0]. A press in IDLE issues burst_len cpu_ce pulses on consecutive clk cycles, with STEP held until the burst is done; burst_len=0 is treated as 1. burst_len is sampled at STEP entry. halt_req=1 during a burst ends it on that cycle with no pulse, then -> IDLE.
- When undefined: the burst_len port is absent and each press issues exactly one pulse.

Test Plan:
Parameters for the bench: DEBOUNCE_CYCLES=4, RATE_BASE=64 (divisors 64/16/4/1).
1. Hold reset=0 for 3 cycles with all inputs toggling -> cpu_ce=0, state=00, step_cnt=0, tick_led=0 throughout and after release.
2. run_en=0; step_btn low 2 cycles (glitch) -> no pulse. Then low 20 cycles and high -> exactly one cpu_ce, state visits 10 for one cycle, step_cnt=1, tick_led=1.
3. rate_sel=2, run_en=1 for 40 cycles after the RUN state is reached -> state=01, exactly 10 pulses spaced 4 cycles apart, first pulse 4 cycles after RUN entry. Switch to rate_sel=3 -> a pulse every cycle.
4. In RUN, assert halt_req on a terminal-count cycle -> no pulse, state=11. Button presses are then ignored. run_en=0 -> IDLE. With halt_req=0, a press -> one pulse.
5. rate_sel=3 run for 65536 pulses -> step_cnt wraps to 0, tick_led=0.
6. With CPU_STEP_BURST_EN: burst_len=5 + press -> 5 consecutive pulses, step_cnt=5. burst_len=0 -> 1 pulse. halt_req after pulse 2 of 5 -> exactly 2 pulses, state=IDLE.

Source files
------------

// File: rtl/cpu_step_ctrl_if.sv
// Signal bundle between the front-panel step controller and its environment.
// The burst_len field exists only when CPU_STEP_BURST_EN is defined.
interface cpu_step_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             run_en;
    logic             step_btn;
    logic [1:0]       rate_sel;
    logic             halt_req;
`ifdef CPU_STEP_BURST_EN
    logic [7:0]       burst_len;
`endif
    logic             cpu_ce;
    logic [1:0]       state;
    logic [CNT_W-1:0] step_cnt;
    logic             tick_led;

    // Board/bench side: drives switches, button and halt; observes the strobe.
    modport master (
        output run_en, step_btn, rate_sel, halt_req,
`ifdef CPU_STEP_BURST_EN
        output burst_len,
`endif
        input  cpu_ce, state, step_cnt, tick_led
    );

    // Controller side.
    modport slave (
        input  run_en, step_btn, rate_sel, halt_req,
`ifdef CPU_STEP_BURST_EN
        input  burst_len,
`endif
        output cpu_ce, state, step_cnt, tick_led
    );
endinterface

// File: rtl/cpu_step_ctrl.sv
// Clock-enable scheduler for the multi-cycle core: free-run, single-step, halt.
// Define CPU_STEP_BURST_EN to let one button press issue a burst of burst_len strobes.
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RATE_BASE       = 50000000,
    parameter int CNT_W           = 16
) (
    input  logic           clk,
    input  logic           reset,
    cpu_step_ctrl_if.slave bus
);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PRE_W = $clog2(RATE_BASE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        HALT = 2'b11
    } state_t;

    logic [1:0]       run_sync;
    logic [1:0]       btn_sync;
    logic             run_en_s;
    logic             btn_s;
    logic             btn_db;
    logic [DB_W-1:0]  db_cnt;
    logic             press;

    state_t           state_q;
    state_t           state_d;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic [31:0]      divisor;
    logic             at_term;
    logic             go_run;
    logic             start_step;
    logic             ce_d;
    logic             cpu_ce_q;
    logic [CNT_W-1:0] step_cnt_q;
    logic             tick_q;
`ifdef CPU_STEP_BURST_EN
    logic [7:0]       burst_rem_q;
    logic [7:0]       burst_rem_d;
`endif

    assign run_en_s = run_sync[1];
    assign btn_s    = btn_sync[1];

    // Debounced level only follows the button after it has stayed different for
    // DEBOUNCE_CYCLES; any return to the old level restarts the count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            run_sync <= 2'b00;
            btn_sync <= 2'b11;
            btn_db   <= 1'b1;
            db_cnt   <= '0;
            press    <= 1'b0;
        end else begin
            run_sync <= {run_sync[0], bus.run_en};
            btn_sync <= {btn_sync[0], bus.step_btn};
            press    <= 1'b0;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES)) begin
                db_cnt <= '0;
                btn_db <= btn_s;
                press  <= ~btn_s;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Divisor is RATE_BASE / 4^rate_sel, never below 1. A >= compare lets a
    // mid-run rate change fire immediately when the prescaler is already past it.
    always_comb begin
        divisor = 32'(RATE_BASE) >> {bus.rate_sel, 1'b0};
        if (divisor == 32'd0) begin
            divisor = 32'd1;
        end
        at_term = (32'(pre_q) >= (divisor - 32'd1));
    end

    assign go_run     = run_en_s & ~bus.halt_req;
    assign start_step = press & ~run_en_s;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (go_run) begin
                    state_d = RUN;
                end else if (start_step) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                if (bus.halt_req) begin
                    state_d = HALT;
                end else if (!run_en_s) begin
                    state_d = IDLE;
                end
            end
            STEP: begin
`ifdef CPU_STEP_BURST_EN
                if (bus.halt_req || (burst_rem_q == 8'd0)) begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            HALT: begin
                if (!run_en_s) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // cpu_ce is a fire-and-forget strobe: no ready/acknowledge comes back from
    // the core, so ce_d is registered and shown exactly in the cycle it applies.
    always_comb begin
        ce_d  = 1'b0;
        pre_d = pre_q;
`ifdef CPU_STEP_BURST_EN
        burst_rem_d = burst_rem_q;
`endif
        case (state_q)
            IDLE: begin
                pre_d = '0;
                if (!go_run && start_step) begin
                    ce_d = 1'b1;
`ifdef CPU_STEP_BURST_EN
                    burst_rem_d = (bus.burst_len == 8'd0) ? 8'd0 : (bus.burst_len - 8'd1);
`endif
                end
            end
            RUN: begin
                if (bus.halt_req || !run_en_s) begin
                    pre_d = '0;
                end else if (at_term) begin
                    ce_d  = 1'b1;
                    pre_d = '0;
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            STEP: begin
`ifdef CPU_STEP_BURST_EN
                if (!bus.halt_req && (burst_rem_q != 8'd0)) begin
                    ce_d        = 1'b1;
                    burst_rem_d = burst_rem_q - 8'd1;
                end
`endif
            end
            HALT: begin
                pre_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pre_q      <= '0;
            cpu_ce_q   <= 1'b0;
            step_cnt_q <= '0;
            tick_q     <= 1'b0;
`ifdef CPU_STEP_BURST_EN
            burst_rem_q <= 8'd0;
`endif
        end else begin
            pre_q    <= pre_d;
            cpu_ce_q <= ce_d;
            if (ce_d) begin
                step_cnt_q <= step_cnt_q + CNT_W'(1);
                tick_q     <= ~tick_q;
            end
`ifdef CPU_STEP_BURST_EN
            burst_rem_q <= burst_rem_d;
`endif
        end
    end

    assign bus.cpu_ce   = cpu_ce_q;
    assign bus.state    = state_q;
    assign bus.step_cnt = step_cnt_q;
    assign bus.tick_led = tick_q;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl: debounce, step, free-run rates, halt, wrap.
// Burst checks are compiled in when CPU_STEP_BURST_EN is defined.
module tb_cpu_step_ctrl;
    localparam int CNT_W = 16;

    typedef struct {
        logic [1:0] rate_sel;
        int         first_lat;
        int         gap;
        int         n_pulses;
    } run_vec_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cpu_step_ctrl_if #(.CNT_W(CNT_W)) bus();

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .RATE_BASE      (64),
        .CNT_W          (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [CNT_W:0]   exp_q[$];
    logic [CNT_W-1:0] model_cnt = '0;
    logic             model_tick = 1'b0;
    int               n_cmp = 0;
    int               n_bad = 0;
    int               ce_seen = 0;
    int               cur_run = 0;
    int               max_run = 0;
    int               step_cycles = 0;
    logic [1:0]       last_ce_state = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++) begin
            model_cnt  = model_cnt + 1'b1;
            model_tick = ~model_tick;
            exp_q.push_back({model_tick, model_cnt});
        end
    endtask

    // One clock; outputs sampled on the falling edge, every strobe scored.
    task automatic cyc();
        logic [CNT_W:0] e;
        @(negedge clk);
        if (bus.state === 2'b10) step_cycles++;
        if (bus.cpu_ce === 1'b1) begin
            ce_seen++;
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
            last_ce_state = bus.state;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_ce: cpu_ce=1 in state %0d, expected no pulse", bus.state);
            end else begin
                e = exp_q.pop_front();
                check("ce_step_cnt", 32'(bus.step_cnt), 32'(e[CNT_W-1:0]));
                check("ce_tick_led", 32'(bus.tick_led), 32'(e[CNT_W]));
            end
        end else begin
            cur_run = 0;
        end
    endtask

    task automatic wait_pulse(input int bound, output int lat);
        lat = 0;
        do begin
            cyc();
            lat++;
        end while (bus.cpu_ce !== 1'b1 && lat < bound);
    endtask

    task automatic wait_state(input logic [1:0] target, input int bound, input string name);
        int n;
        n = 0;
        while (bus.state !== target && n < bound) begin
            cyc();
            n++;
        end
        check(name, 32'(bus.state), 32'(target));
    endtask

    task automatic press_btn(input int low_cycles);
        bus.step_btn = 1'b0;
        repeat (low_cycles) cyc();
        bus.step_btn = 1'b1;
        repeat (16) cyc();
    endtask

    task automatic leave_run();
        bus.halt_req = 1'b1;
        cyc();
        check("halt_state", 32'(bus.state), 32'd3);
        bus.run_en = 1'b0;
        wait_state(2'b00, 10, "halt_to_idle");
        bus.halt_req = 1'b0;
        cyc();
    endtask

    run_vec_t vecs[4];

    initial begin
        int lat;
        int base;
        int s0;
        int guard;

        vecs[0] = '{2'd2, 4, 4, 10};
        vecs[1] = '{2'd1, 16, 16, 3};
        vecs[2] = '{2'd0, 64, 64, 2};
        vecs[3] = '{2'd3, 1, 1, 8};

        reset        = 1'b0;
        bus.run_en   = 1'b0;
        bus.step_btn = 1'b1;
        bus.rate_sel = 2'd0;
        bus.halt_req = 1'b0;
`ifdef CPU_STEP_BURST_EN
        bus.burst_len = 8'd1;
`endif

        // Reset held with all inputs toggling.
        for (int i = 0; i < 3; i++) begin
            bus.run_en   = 1'($urandom_range(0, 1));
            bus.step_btn = 1'($urandom_range(0, 1));
            bus.rate_sel = 2'($urandom_range(0, 3));
            bus.halt_req = 1'($urandom_range(0, 1));
            cyc();
            check("rst_cpu_ce", 32'(bus.cpu_ce), 32'd0);
            check("rst_state", 32'(bus.state), 32'd0);
            check("rst_step_cnt", 32'(bus.step_cnt), 32'd0);
            check("rst_tick_led", 32'(bus.tick_led), 32'd0);
        end
        bus.run_en   = 1'b0;
        bus.step_btn = 1'b1;
        bus.rate_sel = 2'd0;
        bus.halt_req = 1'b0;
        reset        = 1'b1;
        repeat (8) cyc();
        check("post_rst_state", 32'(bus.state), 32'd0);
        check("post_rst_step_cnt", 32'(bus.step_cnt), 32'd0);
        check("post_rst_ce_count", 32'(ce_seen), 32'd0);

        // Short glitch is filtered; a long press gives one STEP strobe.
        base = ce_seen;
        press_btn(2);
        check("glitch_no_pulse", 32'(ce_seen - base), 32'd0);
        push_exp(1);
        s0 = step_cycles;
        press_btn(20);
        check("step_pulses", 32'(ce_seen - base), 32'd1);
        check("step_state_cycles", 32'(step_cycles - s0), 32'd1);
        check("step_ce_in_step", 32'(last_ce_state), 32'd2);
        check("step_cnt_one", 32'(bus.step_cnt), 32'd1);
        check("step_tick_one", 32'(bus.tick_led), 32'd1);
        check("step_back_idle", 32'(bus.state), 32'd0);

        // Free-run rate table.
        foreach (vecs[v]) begin
            bus.rate_sel = vecs[v].rate_sel;
            push_exp(vecs[v].n_pulses);
            bus.run_en = 1'b1;
            wait_state(2'b01, 10, "run_entry");
            wait_pulse(vecs[v].first_lat + 5, lat);
            check("run_first_lat", 32'(lat), 32'(vecs[v].first_lat));
            for (int k = 1; k < vecs[v].n_pulses; k++) begin
                wait_pulse(vecs[v].gap + 5, lat);
                check("run_gap", 32'(lat), 32'(vecs[v].gap));
            end
            leave_run();
            check("run_drained", 32'(exp_q.size()), 32'd0);
        end

        // Mid-run rate change: prescaler already past the new terminal count.
        bus.rate_sel = 2'd1;
        push_exp(6);
        bus.run_en = 1'b1;
        wait_state(2'b01, 10, "rc_run_entry");
        wait_pulse(21, lat);
        check("rc_first_lat16", 32'(lat), 32'd16);
        repeat (10) cyc();
        bus.rate_sel = 2'd2;
        wait_pulse(6, lat);
        check("rc_forced_pulse", 32'(lat), 32'd1);
        wait_pulse(9, lat);
        check("rc_gap4", 32'(lat), 32'd4);
        bus.rate_sel = 2'd3;
        for (int k = 0; k < 3; k++) begin
            wait_pulse(6, lat);
            check("rc_gap1", 32'(lat), 32'd1);
        end
        leave_run();
        check("rc_drained", 32'(exp_q.size()), 32'd0);

        // Halt on a terminal-count cycle, presses ignored in HALT.
        bus.rate_sel = 2'd2;
        push_exp(1);
        bus.run_en = 1'b1;
        wait_state(2'b01, 10, "h_run_entry");
        wait_pulse(9, lat);
        check("h_first_lat", 32'(lat), 32'd4);
        repeat (3) cyc();
        bus.halt_req = 1'b1;
        cyc();
        check("h_state_halt", 32'(bus.state), 32'd3);
        check("h_no_pulse_at_tc", 32'(bus.cpu_ce), 32'd0);
        base = ce_seen;
        press_btn(20);
        check("h_press_ignored", 32'(ce_seen - base), 32'd0);
        check("h_still_halt", 32'(bus.state), 32'd3);
        bus.run_en = 1'b0;
        wait_state(2'b00, 10, "h_to_idle");
        bus.halt_req = 1'b0;
        push_exp(1);
        press_btn(20);
        check("h_step_after", 32'(ce_seen - base), 32'd1);
        check("h_step_in_step", 32'(last_ce_state), 32'd2);
        check("h_step_cnt", 32'(bus.step_cnt), 32'(model_cnt));

`ifdef CPU_STEP_BURST_EN
        bus.burst_len = 8'd5;
        push_exp(5);
        max_run = 0;
        base = ce_seen;
        press_btn(16);
        check("burst5_pulses", 32'(ce_seen - base), 32'd5);
        check("burst5_consecutive", 32'(max_run), 32'd5);
        check("burst5_step_cnt", 32'(bus.step_cnt), 32'(model_cnt));
        check("burst5_idle", 32'(bus.state), 32'd0);

        bus.burst_len = 8'd0;
        push_exp(1);
        max_run = 0;
        base = ce_seen;
        press_btn(16);
        check("burst0_pulses", 32'(ce_seen - base), 32'd1);
        check("burst0_run", 32'(max_run), 32'd1);

        bus.burst_len = 8'd5;
        push_exp(2);
        base = ce_seen;
        bus.step_btn = 1'b0;
        guard = 0;
        while ((ce_seen - base) < 2 && guard < 40) begin
            cyc();
            guard++;
        end
        bus.halt_req = 1'b1;
        cyc();
        check("burst_halt_idle", 32'(bus.state), 32'd0);
        bus.halt_req = 1'b0;
        repeat (4) cyc();
        bus.step_btn = 1'b1;
        repeat (16) cyc();
        check("burst_halt_pulses", 32'(ce_seen - base), 32'd2);
`endif

        check("pre_wrap_drained", 32'(exp_q.size()), 32'd0);

        // Wrap: 65536 strobes from reset bring step_cnt back to 0, LED off.
        reset = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        exp_q.delete();
        model_cnt  = '0;
        model_tick = 1'b0;
        cyc();
        check("wrap_rst_cnt", 32'(bus.step_cnt), 32'd0);
        bus.rate_sel = 2'd3;
        push_exp(65536);
        bus.run_en = 1'b1;
        wait_state(2'b01, 10, "wrap_run_entry");
        guard = 0;
        while (exp_q.size() > 0 && guard < 70000) begin
            cyc();
            guard++;
        end
        bus.halt_req = 1'b1;
        cyc();
        check("wrap_drained", 32'(exp_q.size()), 32'd0);
        check("wrap_step_cnt", 32'(bus.step_cnt), 32'd0);
        check("wrap_tick_led", 32'(bus.tick_led), 32'd0);
        check("wrap_halt", 32'(bus.state), 32'd3);
        bus.run_en = 1'b0;
        wait_state(2'b00, 10, "wrap_to_idle");
        bus.halt_req = 1'b0;
        repeat (4) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
